// File: rtl/key_event_pkg.sv
// Shared types and parameter helpers for the key event bank.
// Holds the per-channel state encoding and the default counter-width rule.
package key_event_pkg;

    typedef enum logic [1:0] {
        REL  = 2'd0,
        PCHK = 2'd1,
        HELD = 2'd2,
        RCHK = 2'd3
    } key_state_t;

    // Smallest width whose range covers both the debounce and the hold/repeat spans.
    function automatic int cnt_w_for(input int deb_cycles, input int long_cycles, input int rep_cycles);
        int span;
        span = (deb_cycles > long_cycles + rep_cycles) ? deb_cycles : long_cycles + rep_cycles;
        return $clog2(span + 32'sd1);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_w_for(16384, 1048576, 262144);

endpackage

// File: rtl/key_event_bank_if.sv
// Pin-side inputs and event outputs of the key event bank, one bit per channel.
// The design takes the slave view; whoever drives the pins takes the master view.
interface key_event_bank_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] i_in;
    logic [N_KEYS-1:0] i_repeat_en;
    logic [N_KEYS-1:0] o_level;
    logic [N_KEYS-1:0] o_press;
    logic [N_KEYS-1:0] o_release;
    logic [N_KEYS-1:0] o_long;
    logic [N_KEYS-1:0] o_repeat;

    modport master (
        output i_in, i_repeat_en,
        input  o_level, o_press, o_release, o_long, o_repeat
    );

    modport slave (
        input  i_in, i_repeat_en,
        output o_level, o_press, o_release, o_long, o_repeat
    );
endinterface

// File: rtl/key_event_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, hold timer with long-press
// and auto-repeat. All event outputs are registered single-cycle pulses.
module key_event_ch
    import key_event_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int LONG_CYCLES     = 1048576,
    parameter int REPEAT_CYCLES   = 262144,
    parameter int CNT_W           = 21
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam logic             REL_PIN   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(LONG_CYCLES + REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(LONG_CYCLES);

    logic             sync1_q, sync2_q;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             pressed_s;

    assign pressed_s = sync2_q ^ REL_PIN;

    // Next-state, counter and pulse decode for the debounce/hold FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            REL: begin
                if (pressed_s) begin
                    state_d = PCHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PCHK: begin
                if (!pressed_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    // Freeze the hold time so a short glitch resumes where it left off.
                    state_d = RCHK;
                    hold_d  = cnt_q;
                    dcnt_d  = CNT_ONE;
                end else begin
                    long_d = (cnt_q == LONG_LAST);
                    if (cnt_q == REP_LAST) begin
                        if (i_repeat_en) begin
                            repeat_d = 1'b1;
                            cnt_d    = REP_LOAD;
                        end else begin
                            cnt_d    = cnt_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            RCHK: begin
                if (pressed_s) begin
                    state_d = HELD;
                    cnt_d   = hold_q;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = REL;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                    dcnt_d    = '0;
                    hold_d    = '0;
                end else begin
                    dcnt_d    = dcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                dcnt_d  = '0;
                hold_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchroniser, FSM state, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= REL_PIN;
            sync2_q   <= REL_PIN;
            state_q   <= REL;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= i_in;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
    assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_event_bank.sv
// Bank of N_KEYS independent key channels between the board pins and the
// application's key inputs; each channel is a key_event_ch instance.
module key_event_bank
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int LONG_CYCLES     = 1048576,
    parameter int REPEAT_CYCLES   = 262144,
    parameter int CNT_W           = cnt_w_for(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    key_event_bank_if.slave  bus
);

    logic [N_KEYS-1:0] level_s;
    logic [N_KEYS-1:0] press_s;
    logic [N_KEYS-1:0] release_s;
    logic [N_KEYS-1:0] long_s;
    logic [N_KEYS-1:0] repeat_s;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_event_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_in        (bus.i_in[g]),
            .i_repeat_en (bus.i_repeat_en[g]),
            .o_level     (level_s[g]),
            .o_press     (press_s[g]),
            .o_release   (release_s[g]),
            .o_long      (long_s[g]),
            .o_repeat    (repeat_s[g])
        );
    end

    assign bus.o_level   = level_s;
    assign bus.o_press   = press_s;
    assign bus.o_release = release_s;
    assign bus.o_long    = long_s;
    assign bus.o_repeat  = repeat_s;

endmodule

// File: tb/tb_key_event_bank.sv
// Bench for key_event_bank: directed scenarios then random pin activity, all
// outputs compared each cycle against a run-length/hold-age reference model.
module tb_key_event_bank;

    localparam int NK   = 4;
    localparam bit AL   = 1'b1;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    key_event_bank_if #(.N_KEYS(NK)) bus ();

    key_event_bank #(
        .N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: pin delay line, accepted level, run of disagreeing samples, hold age.
    bit pin_d0 [NK];
    bit pin_d1 [NK];
    bit m_lvl  [NK];
    int m_run  [NK];
    int m_age  [NK];
    logic [NK-1:0] e_level, e_press, e_release, e_long, e_repeat;

    int n_press [NK], n_release [NK], n_long [NK], n_repeat [NK];
    int press_at [NK], release_at [NK], long_at [NK];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit p;
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        for (int c = 0; c < NK; c++) begin
            if (rst) begin
                pin_d0[c] = AL; pin_d1[c] = AL;
                m_lvl[c] = 1'b0; m_run[c] = 0; m_age[c] = 0;
            end else begin
                p = pin_d1[c] ^ AL;
                if (!m_lvl[c]) begin
                    if (p) begin
                        m_run[c]++;
                        if (m_run[c] == DEB) begin
                            m_lvl[c] = 1'b1; e_press[c] = 1'b1; m_run[c] = 0; m_age[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end else if (p) begin
                    if (m_run[c] != 0) begin
                        m_run[c] = 0;
                    end else begin
                        e_long[c] = (m_age[c] == LONG - 1);
                        if (m_age[c] == LONG + REP - 1) begin
                            if (bus.i_repeat_en[c]) begin
                                e_repeat[c] = 1'b1; m_age[c] = LONG;
                            end
                        end else begin
                            m_age[c]++;
                        end
                    end
                end else begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_lvl[c] = 1'b0; e_release[c] = 1'b1; m_run[c] = 0; m_age[c] = 0;
                    end
                end
                pin_d1[c] = pin_d0[c];
                pin_d0[c] = bus.i_in[c];
            end
            e_level[c] = m_lvl[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("level",   32'(bus.o_level),   32'(e_level));
        chk("press",   32'(bus.o_press),   32'(e_press));
        chk("release", 32'(bus.o_release), 32'(e_release));
        chk("long",    32'(bus.o_long),    32'(e_long));
        chk("repeat",  32'(bus.o_repeat),  32'(e_repeat));
        for (int c = 0; c < NK; c++) begin
            if (bus.o_press[c] === 1'b1)   begin n_press[c]++;   press_at[c]   = cyc; end
            if (bus.o_release[c] === 1'b1) begin n_release[c]++; release_at[c] = cyc; end
            if (bus.o_long[c] === 1'b1)    begin n_long[c]++;    long_at[c]    = cyc; end
            if (bus.o_repeat[c] === 1'b1)  begin n_repeat[c]++; end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_stats();
        for (int c = 0; c < NK; c++) begin
            n_press[c] = 0; n_release[c] = 0; n_long[c] = 0; n_repeat[c] = 0;
            press_at[c] = -1; release_at[c] = -1; long_at[c] = -1;
        end
    endtask

    initial begin
        int d;
        bus.i_in = 4'hF;
        bus.i_repeat_en = 4'h0;
        rst = 1'b1;
        clr_stats();
        ticks(2);
        chk("reset_level", 32'(bus.o_level), 32'd0);
        rst = 1'b0;
        ticks(4);

        // Bounce shorter than the debounce window.
        clr_stats();
        bus.i_in[0] = 1'b0; ticks(3);
        bus.i_in[0] = 1'b1; ticks(10);
        chk("bounce_press", 32'(n_press[0]), 32'd0);

        // Clean press and release on key 0.
        clr_stats();
        d = cyc;
        bus.i_in[0] = 1'b0; ticks(15);
        bus.i_in[0] = 1'b1; ticks(10);
        chk("press_latency",   32'(press_at[0] - d),   32'd6);
        chk("release_latency", 32'(release_at[0] - d), 32'd21);

        // Long press with auto-repeat on key 1, held 70 cycles.
        clr_stats();
        bus.i_repeat_en[1] = 1'b1;
        d = cyc;
        bus.i_in[1] = 1'b0; ticks(70);
        bus.i_in[1] = 1'b1; ticks(10);
        chk("long_latency", 32'(long_at[1] - d), 32'd26);
        chk("repeat_count", 32'(n_repeat[1]),    32'd5);

        // Same hold with repeat disabled.
        clr_stats();
        bus.i_repeat_en[1] = 1'b0;
        bus.i_in[1] = 1'b0; ticks(70);
        bus.i_in[1] = 1'b1; ticks(10);
        chk("norep_long",   32'(n_long[1]),   32'd1);
        chk("norep_repeat", 32'(n_repeat[1]), 32'd0);

        // Short release glitch after the long press.
        clr_stats();
        bus.i_repeat_en[1] = 1'b1;
        bus.i_in[1] = 1'b0; ticks(30);
        bus.i_in[1] = 1'b1; ticks(2);
        bus.i_in[1] = 1'b0; ticks(30);
        chk("glitch_no_release", 32'(n_release[1]), 32'd0);
        bus.i_in[1] = 1'b1; ticks(10);

        // Keys 0 and 3 together.
        clr_stats();
        bus.i_in = 4'b0110; ticks(10);
        chk("parallel_same_cycle", 32'(press_at[3]), 32'(press_at[0]));
        chk("parallel_quiet", 32'(n_press[1] + n_press[2]), 32'd0);
        bus.i_in = 4'hF; ticks(10);

        // Reset while key 2 is held.
        clr_stats();
        bus.i_in[2] = 1'b0; ticks(29);
        rst = 1'b1; tick();
        chk("rst_outputs", 32'({bus.o_level, bus.o_press, bus.o_release, bus.o_long, bus.o_repeat}), 32'd0);
        d = cyc;
        rst = 1'b0; ticks(10);
        chk("rst_repress", 32'(press_at[2] - d), 32'd6);
        chk("rst_no_release", 32'(n_release[2]), 32'd0);
        bus.i_in[2] = 1'b1; ticks(10);

        // Random pin activity, repeat-enable changes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NK; c++) begin
                if ($urandom_range(0, 15) == 0) bus.i_in[c] = ~bus.i_in[c];
                if ($urandom_range(0, 31) == 0) bus.i_repeat_en[c] = ~bus.i_repeat_en[c];
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        ticks(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
